// File: rtl/deoxys_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the Deoxys-BC round controller.
package deoxys_ctrl_pkg;

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_t;

  // Number of clocked iterations needed to apply all round constants.
  function automatic int unsigned calc_iters(int unsigned rnds_per_clk,
                                             int unsigned num_steps);
    return (num_steps + rnds_per_clk - 1) / rnds_per_clk;
  endfunction

  // Lane mask for the final iteration: only the lanes that still map to a
  // valid constant index are enabled.
  function automatic logic [63:0] calc_last_mask(int unsigned rnds_per_clk,
                                                 int unsigned num_steps);
    int unsigned rem;
    logic [63:0] m;
    rem = num_steps - rnds_per_clk * (calc_iters(rnds_per_clk, num_steps) - 1);
    m   = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < rem) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/deoxys_round_ctrl.sv
// Iteration controller for the Deoxys-BC datapath: frames one block per
// valid/ready handshake and drives the constant generator's cnt input.
module deoxys_round_ctrl
  import deoxys_ctrl_pkg::*;
#(
  parameter int unsigned RNDS_PER_CLK = 1,
  parameter int unsigned NUM_STEPS    = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    load,
  output logic                    round_en,
  output logic [CNT_W-1:0]        cnt,
  output logic [RNDS_PER_CLK-1:0] rnd_mask,
  output logic                    last_iter,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int unsigned ITERS = calc_iters(RNDS_PER_CLK, NUM_STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);
  localparam logic [63:0] LAST_MASK_FULL = calc_last_mask(RNDS_PER_CLK, NUM_STEPS);
  localparam logic [RNDS_PER_CLK-1:0] LAST_MASK = LAST_MASK_FULL[RNDS_PER_CLK-1:0];

  if (ITERS > 64 || ITERS == 0) begin : g_iters_check
    $error("deoxys_round_ctrl: ITERS must be in 1..64");
  end

  ctrl_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             is_last;

  assign cnt = cnt_q;

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Next-state, counter update and strobe/mask outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    in_ready  = 1'b0;
    round_en  = 1'b0;
    out_valid = 1'b0;
    rnd_mask  = '0;
    is_last   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        round_en = 1'b1;
        is_last  = (cnt_q == LAST_CNT);
        rnd_mask = is_last ? LAST_MASK : '1;
        if (is_last) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        // Accepting the next block while handing off the result avoids an
        // IDLE bubble between back-to-back blocks.
        in_ready  = out_ready;
        if (out_ready) begin
          state_nxt = in_valid ? ST_RUN : ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (flush) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end

    load = in_valid & in_ready & ~flush;
  end

  assign last_iter = is_last;
  assign busy      = (state != ST_IDLE);

endmodule
